// File: rtl/q_to_fp32.sv
// q_to_fp32: sequential signed Q(FIXED_BITS.FRACTIONAL_BITS) to IEEE-754
// binary32 converter. It normalises one bit per cycle, so latency depends on
// the position of the leading one. Both sides use a valid/ready handshake.
module q_to_fp32 #(
  parameter int FIXED_BITS      = 8,
  parameter int FRACTIONAL_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FIXED_BITS+FRACTIONAL_BITS-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_data,
  output logic                                 out_inexact
);

  localparam int W = FIXED_BITS + FRACTIONAL_BITS;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ABS   = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  // Biased exponent of a magnitude whose leading one already sits in bit W-1.
  localparam int         EXP_BASE_I = 127 + W - 1 - FRACTIONAL_BITS;
  localparam logic [7:0] EXP_BASE   = EXP_BASE_I[7:0];

  logic [2:0]   state;
  logic         sign;
  logic [W-1:0] mag;
  logic [5:0]   shift;

  // Rounding datapath, consumed only in ROUND.
  logic [54:0]  aligned;
  logic         lsb;
  logic         guard;
  logic         sticky;
  logic         round_up;
  logic [7:0]   exp_pre;
  logic [30:0]  rounded;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // Align the fraction bits below the hidden one at the top of a 55-bit field:
  // bits 54:32 are the mantissa, 31 is guard, 30:0 feed sticky. For W<=24 the
  // guard/sticky positions only ever hold zero padding, so the result is exact.
  // A mantissa carry out of the {exponent, mantissa} add bumps the exponent.
  always_comb begin
    aligned  = {mag[W-2:0], {(56-W){1'b0}}};
    lsb      = aligned[32];
    guard    = aligned[31];
    sticky   = |aligned[30:0];
    round_up = guard & (sticky | lsb);
    exp_pre  = EXP_BASE - {2'b00, shift};
    rounded  = {exp_pre, aligned[54:32]} + {30'd0, round_up};
  end

  // Conversion FSM and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mag         <= '0;
      shift       <= '0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag   <= in_data;
            state <= ABS;
          end
        end
        ABS: begin
          sign <= mag[W-1];
          if (mag[W-1]) begin
            mag <= -mag;
          end
          shift <= '0;
          if (mag == '0) begin
            out_data    <= '0;
            out_inexact <= 1'b0;
            state       <= OUT;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (!mag[W-1]) begin
            mag   <= mag << 1;
            shift <= shift + 6'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_data    <= {sign, rounded};
          out_inexact <= guard | sticky;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_to_fp32.sv
// Testbench for q_to_fp32: a W=16,F=8 instance and a W=32,F=0 instance,
// checked through an expected-result queue.
module tb_q_to_fp32;

  typedef struct {
    logic [31:0] data;
    logic        inexact;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [15:0] a_in_data = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [31:0] a_out_data;
  logic        a_out_inexact;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [31:0] b_out_data;
  logic        b_out_inexact;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  q_to_fp32 #(.FIXED_BITS(8), .FRACTIONAL_BITS(8)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_inexact(a_out_inexact)
  );

  q_to_fp32 #(.FIXED_BITS(32), .FRACTIONAL_BITS(0)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_inexact(b_out_inexact)
  );

  // Reference: value/256 as a float, built from the double representation.
  // Every W=16 input is exact in binary32.
  function automatic logic [31:0] ref16(input logic [15:0] v);
    real         r;
    logic [63:0] d;
    int          e;
    if (v == 16'h0000) return 32'h0;
    r = $itor($signed(v)) / 256.0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic run_a(input logic [15:0] v, input logic [31:0] ed,
                       input logic ei, input int lat, input string name);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (!a_in_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
    a_in_valid = 1'b1;
    a_in_data  = v;
    sb.push_back('{ed, ei, lat});
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    cnt = 1;
    while (!a_out_valid && cnt < 60) begin @(posedge clk); #1; cnt++; end
    e = sb.pop_front();
    checks++;
    if (cnt !== e.lat) begin
      failures++;
      $display("FAIL %s latency got %0d want %0d", name, cnt, e.lat);
    end
    checks++;
    if (a_out_data !== e.data) begin
      failures++;
      $display("FAIL %s out_data got %08h want %08h", name, a_out_data, e.data);
    end
    checks++;
    if (a_out_inexact !== e.inexact) begin
      failures++;
      $display("FAIL %s inexact got %0b want %0b", name, a_out_inexact, e.inexact);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [31:0] v, input logic [31:0] ed,
                       input logic ei, input int lat, input string name);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (!b_in_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
    b_in_valid = 1'b1;
    b_in_data  = v;
    sb.push_back('{ed, ei, lat});
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    cnt = 1;
    while (!b_out_valid && cnt < 80) begin @(posedge clk); #1; cnt++; end
    e = sb.pop_front();
    checks++;
    if (cnt !== e.lat) begin
      failures++;
      $display("FAIL %s latency got %0d want %0d", name, cnt, e.lat);
    end
    checks++;
    if (b_out_data !== e.data) begin
      failures++;
      $display("FAIL %s out_data got %08h want %08h", name, b_out_data, e.data);
    end
    checks++;
    if (b_out_inexact !== e.inexact) begin
      failures++;
      $display("FAIL %s inexact got %0b want %0b", name, b_out_inexact, e.inexact);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
    checks++;
    if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
    checks++;
    if (a_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got %08h want 0", a_out_data); end
    checks++;
    if (a_out_inexact !== 1'b0) begin failures++; $display("FAIL reset_inexact got %0b want 0", a_out_inexact); end
    checks++;
    if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset32_in_ready got %0b want 1", b_in_ready); end
    checks++;
    if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset32_out_valid got %0b want 0", b_out_valid); end
  endtask

  task automatic test_directed16();
    run_a(16'h0100, 32'h3F800000, 1'b0, 11, "one");
    run_a(16'hFF80, 32'hBF000000, 1'b0, 12, "minus_half");
    run_a(16'h8000, 32'hC3000000, 1'b0, 4,  "most_negative");
    run_a(16'h0001, 32'h3B800000, 1'b0, 19, "smallest");
    run_a(16'h0000, 32'h00000000, 1'b0, 2,  "zero");
    run_a(16'h7FFF, 32'h42FFFE00, 1'b0, 5,  "largest");
  endtask

  task automatic test_rounding32();
    run_b(32'h7FFFFFFF, 32'h4F000000, 1'b1, 5,  "w32_carry");
    run_b(32'h01000001, 32'h4B800000, 1'b1, 11, "w32_tie_down");
    run_b(32'h01000003, 32'h4B800002, 1'b1, 11, "w32_tie_up");
    run_b(32'h80000000, 32'hCF000000, 1'b0, 4,  "w32_most_negative");
  endtask

  task automatic test_backpressure();
    int cnt;
    cnt = 0;
    while (!a_in_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
    a_in_valid = 1'b1;
    a_in_data  = 16'h0200;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    cnt = 1;
    while (!a_out_valid && cnt < 60) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (cnt !== 10) begin failures++; $display("FAIL bp_latency got %0d want 10", cnt); end
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i % 2 == 0);
      a_in_data  = 16'h1234;
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got %0b want 1", i, a_out_valid); end
      checks++;
      if (a_out_data !== 32'h40000000) begin failures++; $display("FAIL bp_data[%0d] got %08h want 40000000", i, a_out_data); end
      checks++;
      if (a_out_inexact !== 1'b0) begin failures++; $display("FAIL bp_inexact[%0d] got %0b want 0", i, a_out_inexact); end
      checks++;
      if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, a_in_ready); end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got %0b want 1", a_in_ready); end
    checks++;
    if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after got %0b want 0", a_out_valid); end
    run_a(16'hFF80, 32'hBF000000, 1'b0, 12, "after_bp");
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    while (!a_in_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
    a_in_valid = 1'b1;
    a_in_data  = 16'h0001;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %0b want 0", a_out_valid); end
    checks++;
    if (a_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %0b want 1", a_in_ready); end
    run_a(16'h0100, 32'h3F800000, 1'b0, 11, "after_midrst");
    run_a(16'hFE80, 32'hBFC00000, 1'b0, 11, "after_midrst2");
  endtask

  task automatic test_back_to_back();
    int got;
    got = 0;
    sb.delete();
    fork
      begin : producer
        logic [15:0] v;
        int cnt;
        for (int i = 0; i < 100; i++) begin
          v = (i == 0) ? 16'h8000 : (i == 1) ? 16'h0000 : 16'($urandom);
          cnt = 0;
          while (!a_in_ready && cnt < 200) begin @(posedge clk); #1; cnt++; end
          a_in_valid = 1'b1;
          a_in_data  = v;
          sb.push_back('{ref16(v), 1'b0, 0});
          @(posedge clk); #1;
          a_in_valid = 1'b0;
        end
      end
      begin : consumer
        exp_t e;
        int   cyc;
        cyc = 0;
        while (got < 100 && cyc < 20000) begin
          @(posedge clk); #1;
          cyc++;
          a_out_ready = 1'($urandom_range(0, 1));
          if (a_out_valid && a_out_ready) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL b2b_extra got %08h want none", a_out_data);
            end else begin
              e = sb.pop_front();
              if (a_out_data !== e.data || a_out_inexact !== 1'b0) begin
                failures++;
                $display("FAIL b2b[%0d] got %08h/%0b want %08h/0", got, a_out_data, a_out_inexact, e.data);
              end
            end
            got++;
          end
        end
        @(posedge clk); #1;
        a_out_ready = 1'b0;
      end
    join
    checks++;
    if (got !== 100) begin failures++; $display("FAIL b2b_count got %0d want 100", got); end
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL b2b_leftover got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_directed16();
    test_rounding32();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_to_fp32.md
Name: q_to_fp32

Overview:
- Sequential converter from signed Q-format fixed-point to IEEE-754 single precision.
- It is the export path for results produced by the q_format arithmetic unit.
- It uses a valid/ready handshake on both sides.
- Normalization shifts one bit per cycle, keeping the datapath small at the cost of variable latency.

Parameters:
- FIXED_BITS, 8, integer bits of input (including sign).
- FRACTIONAL_BITS, 8, fractional bits of input. W = FIXED_BITS+FRACTIONAL_BITS, legal range 2..32.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  converter can accept a word.
- in_data  input  W  signed two's-complement Q(FIXED_BITS.FRACTIONAL_BITS) value.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  IEEE-754 binary32 result.
- out_inexact  output  1  rounding discarded nonzero bits.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, out_data=0, out_inexact=0. in_ready=1 from the first cycle after rst deasserts. rst mid-conversion discards the word in flight.
- in_ready = (state==IDLE), decoded from registered state only. out_valid = (state==OUT). out_data and out_inexact are registered and held stable while out_valid=1 && out_ready=0.
- IDLE: on in_valid&&in_ready, register in_data and move to ABS.
- ABS: sign = in_data[W-1].
  - Compute mag = |in_data| as W-bit unsigned; the most negative input gives 2^(W-1), which fits.
  - If mag==0: out_data=0x00000000 (+0, sign forced 0), inexact=0, go to OUT.
  - Otherwise clear shift count s and go to NORM.
- NORM: each cycle, if mag[W-1]==0 then mag<<=1 and s++; otherwise go to ROUND. NORM occupies s+1 cycles.
- ROUND, exponent: biased exponent = 127 + (W-1-FRACTIONAL_BITS) - s.
- ROUND, mantissa when W-1 ≤ 23: mantissa = mag[W-2:0] left-aligned and zero-padded to 23 bits; inexact=0.
- ROUND, mantissa when W-1 > 23: mantissa = mag[W-2:W-24].
  - guard = mag[W-25]; sticky = OR of the bits below guard.
  - Round to nearest, ties to even.
  - A mantissa carry-out sets mantissa=0 and exponent+1.
  - inexact = guard|sticky.
- Range: no overflow, underflow or denormal is reachable for W≤32, so no special-case logic is required.
- ROUND is followed by OUT.
- OUT: hold until out_ready. On the handshake go to IDLE. in_ready rises the following cycle (no same-cycle bypass).
- Latency, with acceptance at cycle t:
  - out_valid is asserted at t+4+s, where s = W-1-(index of leading one of mag).
  - Zero input: out_valid at t+2.
  - Worst case: t+4+(W-1).
- in_valid while busy is ignored. The upstream holds the word until in_ready.

Test Plan:
- W=16,F=8, in 0x0100 (1.0) -> out_data 0x3F800000, inexact 0, out_valid exactly t+11 (s=7).
- W=16,F=8: 0xFF80 (-0.5) -> 0xBF000000 at t+12; 0x8000 (-128.0) -> 0xC3000000 at t+4; 0x0001 (2^-8) -> 0x3B800000 at t+19; 0x0000 -> 0x00000000 at t+2.
- W=32,F=0 instance:
  - 0x7FFFFFFF -> 0x4F000000, inexact 1 (round-up carry into exponent).
  - 0x01000001 -> 0x4B800000, inexact 1 (tie to even).
  - 0x01000003 -> 0x4B800002, inexact 1 (tie rounds up to even).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data and out_inexact stay stable; in_ready stays 0; in_valid pulses are ignored.
  - After the handshake, in_ready=1 on the next cycle.
- Assert rst during NORM -> next cycle out_valid=0, in_ready=1. A new word converts correctly with no residue of the aborted one.
- Back-to-back stream of 100 random W=16,F=8 values with random out_ready -> every out_data matches the reference model (value/256 as float), order preserved, no drops or duplicates.
